// File: rtl/player_pkg.sv
// player_pkg: definitions shared by the front-panel command encoder.
//   - 3-bit player command codes. CMD_LOAD is listed for completeness;
//     the encoder never drives it.
//   - Encodings for the shadow copy of the player state.
//   - Encodings for the issue FSM states.
//   - Helpers that decide whether a command is legal and what shadow
//     state follows it.
package player_pkg;

  localparam logic [2:0] CMD_LOAD  = 3'b000;
  localparam logic [2:0] CMD_PLAY  = 3'b001;
  localparam logic [2:0] CMD_PAUSE = 3'b010;
  localparam logic [2:0] CMD_NEXT  = 3'b011;
  localparam logic [2:0] CMD_PREV  = 3'b100;
  localparam logic [2:0] CMD_IDLE  = 3'b111;

  // Bit positions of the buttons on the btn bus.
  localparam int BTN_PLAY  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;
  localparam int BTN_PREV  = 3;

  typedef enum logic [1:0] {
    SH_LOAD  = 2'b00,
    SH_PLAY  = 2'b01,
    SH_PAUSE = 2'b10
  } shadow_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10
  } issue_state_t;

  // Returns 1 when the player would act on cmd while it is in state sh.
  function automatic logic cmd_legal(input logic [2:0] cmd, input shadow_t sh);
    logic ok;
    ok = 1'b0;
    unique case (cmd)
      CMD_PLAY:           ok = (sh == SH_LOAD) || (sh == SH_PAUSE);
      CMD_PAUSE:          ok = (sh == SH_PLAY);
      CMD_NEXT, CMD_PREV: ok = (sh == SH_PLAY);
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns the player state after it accepts a legal command.
  // NEXT and PREV leave the state at PLAY.
  function automatic shadow_t shadow_after(input logic [2:0] cmd, input shadow_t sh);
    shadow_t nxt;
    nxt = sh;
    unique case (cmd)
      CMD_PLAY:  nxt = SH_PLAY;
      CMD_PAUSE: nxt = SH_PAUSE;
      default:   nxt = sh;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/player_cmd_encoder_debounce.sv
// btn_debounce: cleans up one raw push-button.
//   - A 2-flop synchronizer, then a debouncer built on a saturating counter.
//   - The debounced level changes only after the synchronized input has
//     differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   - rise is a one-cycle pulse, registered in the same edge where the level
//     changes from 0 to 1.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   raw    asynchronous button input, active-high
//   rise   one-cycle pulse on each accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: every register in a clocked block is written with <=, so all
  // flops sample the values from before the edge and the synchronizer
  // stages really form a two-stage pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th differing sample, so the new value
        // is accepted now. The >= compare keeps the counter from running
        // past CNT_LAST, so it can never wrap.
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/player_cmd_encoder.sv
// player_cmd_encoder: turns four front-panel buttons into single-cycle player
// commands, each followed by an idle gap.
//   - Each button is debounced, and each accepted press sets a pending bit.
//   - The issue FSM serves pending bits in priority order:
//     pause > play > next > prev.
//   - Presses that the mirrored player state says would be ignored are
//     dropped instead of issued.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high
//   btn[3:0]      raw buttons: [0] play, [1] pause, [2] next, [3] prev
//   command[2:0]  command code to the player; CMD_IDLE when nothing is issued
//   cmd_valid     high in the cycles where command != CMD_IDLE
//   dropped       one-cycle pulse when a pending press is discarded as illegal
//   shadow_state  mirrored player state: 00 LOAD, 01 PLAY, 10 PAUSE
module player_cmd_encoder
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [2:0] command,
  output logic       cmd_valid,
  output logic       dropped,
  output logic [1:0] shadow_state
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [3:0]    rise;
  logic [3:0]    pend;
  logic [3:0]    pend_next;
  logic [3:0]    pend_clr;
  logic [3:0]    sel_mask;
  logic [2:0]    sel_code;
  logic [2:0]    code_q;
  logic [2:0]    code_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_next;
  issue_state_t  state;
  issue_state_t  state_next;
  shadow_t       shadow_q;
  shadow_t       shadow_next;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn[i]),
      .rise (rise[i])
    );
  end

  // Picks the highest-priority pending press.
  always_comb begin
    sel_mask = '0;
    sel_code = CMD_IDLE;
    if (pend[BTN_PAUSE]) begin
      sel_mask[BTN_PAUSE] = 1'b1;
      sel_code            = CMD_PAUSE;
    end else if (pend[BTN_PLAY]) begin
      sel_mask[BTN_PLAY] = 1'b1;
      sel_code           = CMD_PLAY;
    end else if (pend[BTN_NEXT]) begin
      sel_mask[BTN_NEXT] = 1'b1;
      sel_code           = CMD_NEXT;
    end else if (pend[BTN_PREV]) begin
      sel_mask[BTN_PREV] = 1'b1;
      sel_code           = CMD_PREV;
    end
  end

  // Issue FSM: next-state logic and outputs.
  // NOTE: every signal this block drives gets its default at the top. Any
  // path through the case that does not assign a signal then still gives it
  // a value, so no latch is inferred.
  always_comb begin
    state_next   = state;
    code_next    = code_q;
    shadow_next  = shadow_q;
    gap_cnt_next = gap_cnt;
    pend_clr     = '0;
    command      = CMD_IDLE;
    cmd_valid    = 1'b0;
    dropped      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pend != '0) begin
          pend_clr = sel_mask;
          if (cmd_legal(sel_code, shadow_q)) begin
            state_next = ST_ISSUE;
            code_next  = sel_code;
          end else begin
            dropped = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        command      = code_q;
        cmd_valid    = 1'b1;
        shadow_next  = shadow_after(code_q, shadow_q);
        gap_cnt_next = '0;
        state_next   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt + GW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // When a press arrives in the same cycle its pending bit is served, the
    // set wins and the press stays pending.
    pend_next = (pend & ~pend_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pend     <= '0;
      code_q   <= CMD_IDLE;
      gap_cnt  <= '0;
      shadow_q <= SH_LOAD;
    end else begin
      state    <= state_next;
      pend     <= pend_next;
      code_q   <= code_next;
      gap_cnt  <= gap_cnt_next;
      shadow_q <= shadow_next;
    end
  end

  assign shadow_state = shadow_q;

endmodule

// File: tb/tb_player_cmd_encoder.sv
// Self-checking bench for player_cmd_encoder, built with DEBOUNCE_CYCLES=4
// and GAP_CYCLES=2.
//   - Directed scenario tasks check their results against constants.
//   - A randomized phase checks every cycle against a reference model kept in
//     this bench. The model treats a debounced button as "the last
//     DEBOUNCE_CYCLES synchronized samples all disagree with the level". It
//     treats command issue as a hold-off countdown over pending presses.
module tb_player_cmd_encoder;

  localparam int DEB = 4;
  localparam int GAP = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn   = 4'h0;
  logic [2:0] command;
  logic       cmd_valid;
  logic       dropped;
  logic [1:0] shadow_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_cmd_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .command     (command),
    .cmd_valid   (cmd_valid),
    .dropped     (dropped),
    .shadow_state(shadow_state)
  );

  // ---------------- reference model ----------------
  // Buttons: 0 play, 1 pause, 2 next, 3 prev. Shadow: 0 LOAD, 1 PLAY, 2 PAUSE.
  // hist[b][j] is the raw sample taken j edges ago. The synchronizer output
  // that the debouncer sees at an edge is hist[b][2].
  int hist[4][DEB+2];
  int lvl[4];
  int rise_m[4];
  int pend_m[4];
  int hold_m;   // cycles left before idle; GAP+1 marks the issue cycle
  int code_m;
  int shadow_m;

  function automatic void m_reset();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < DEB + 2; j++) hist[b][j] = 0;
      lvl[b] = 0; rise_m[b] = 0; pend_m[b] = 0;
    end
    hold_m = 0; code_m = 7; shadow_m = 0;
  endfunction

  function automatic int m_pick();
    if (pend_m[1] != 0) return 1;
    if (pend_m[0] != 0) return 0;
    if (pend_m[2] != 0) return 2;
    if (pend_m[3] != 0) return 3;
    return -1;
  endfunction

  function automatic int m_code(input int b);
    case (b)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_legal(input int b, input int sh);
    if (b == 0) return sh != 1;
    return sh == 1;
  endfunction

  function automatic int exp_cmd();
    return (hold_m == GAP + 1) ? code_m : 7;
  endfunction

  function automatic int exp_drop();
    int pk;
    pk = m_pick();
    return (hold_m == 0 && pk >= 0 && !m_legal(pk, shadow_m)) ? 1 : 0;
  endfunction

  function automatic void model_edge(input logic r, input logic [3:0] b_in);
    int  pk;
    int  new_hold;
    bool_flip : begin end
    if (r) begin
      m_reset();
      return;
    end
    pk = (hold_m == 0) ? m_pick() : -1;
    if (hold_m == GAP + 1) begin
      if (code_m == 1) shadow_m = 1;
      else if (code_m == 2) shadow_m = 2;
    end
    if (pk >= 0) begin
      pend_m[pk] = 0;
      if (m_legal(pk, shadow_m)) begin
        code_m   = m_code(pk);
        new_hold = GAP + 1;
      end else begin
        new_hold = 0;
      end
    end else begin
      new_hold = (hold_m > 0) ? hold_m - 1 : 0;
    end
    hold_m = new_hold;
    for (int b = 0; b < 4; b++) begin
      int all_diff;
      if (rise_m[b] != 0) pend_m[b] = 1;
      for (int j = DEB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = int'(b_in[b]);
      all_diff = 1;
      for (int j = 2; j < DEB + 2; j++) if (hist[b][j] == lvl[b]) all_diff = 0;
      rise_m[b] = 0;
      if (all_diff != 0) begin
        lvl[b]    = 1 - lvl[b];
        rise_m[b] = lvl[b];
      end
    end
  endfunction

  // The DUT and the model both sample at the same posedge. Outputs are
  // observed and inputs driven on the following negedge.
  task automatic tick();
    @(posedge clk);
    model_edge(reset, btn);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    btn   = 4'hF;
    tick();
    tick();
    checks++; if (command !== 3'b111) begin errors++; $display("FAIL reset_command: got %b expected 111", command); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL reset_shadow: got %b expected 00", shadow_state); end
    reset = 1'b0;
    btn   = 4'h0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b0 || dropped !== 1'b0) begin
        errors++; $display("FAIL reset_buttons_ignored: cycle %0d valid %b dropped %b expected 0 0", i, cmd_valid, dropped);
      end
    end
  endtask

  task automatic test_play_latency();
    btn = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (command !== ((i == DEB + 4) ? 3'b001 : 3'b111) || cmd_valid !== (i == DEB + 4)) begin
        errors++; $display("FAIL play_latency: cycle %0d got cmd %b valid %b", i, command, cmd_valid);
      end
    end
    checks++; if (shadow_state !== 2'b01) begin errors++; $display("FAIL play_shadow: got %b expected 01", shadow_state); end
    btn = 4'h0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_bounce();
    int nv;
    int nd;
    nv = 0; nd = 0;
    for (int i = 0; i < 24; i++) begin
      btn[0] = (i < 12) && ((i / 2) % 2 == 0);
      tick();
      if (cmd_valid === 1'b1) nv++;
      if (dropped === 1'b1) nd++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL bounce_valid: got %0d commands expected 0", nv); end
    checks++; if (nd != 0) begin errors++; $display("FAIL bounce_dropped: got %0d drops expected 0", nd); end
  endtask

  task automatic test_back_to_back();
    int n;
    int t[2];
    logic [2:0] c[2];
    n = 0; t[0] = 0; t[1] = 0; c[0] = 3'b0; c[1] = 3'b0;
    btn = 4'b1100;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) btn = 4'h0;
      tick();
      if (cmd_valid === 1'b1) begin
        if (n < 2) begin t[n] = i; c[n] = command; end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_count: got %0d commands expected 2", n); end
    checks++; if (c[0] !== 3'b011) begin errors++; $display("FAIL b2b_first: got %b expected 011", c[0]); end
    checks++; if (c[1] !== 3'b100) begin errors++; $display("FAIL b2b_second: got %b expected 100", c[1]); end
    // Issue cycle, GAP gap cycles, then the idle cycle that selects the next press.
    checks++; if (t[1] - t[0] != GAP + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t[1] - t[0], GAP + 2); end
    checks++; if (shadow_state !== 2'b01) begin errors++; $display("FAIL b2b_shadow: got %b expected 01", shadow_state); end
  endtask

  task automatic test_drop_in_load();
    int nd;
    int nv;
    int td;
    nd = 0; nv = 0; td = -1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    btn   = 4'b0100;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dropped === 1'b1) begin nd++; td = i; end
      if (cmd_valid === 1'b1 || command !== 3'b111) nv++;
    end
    btn = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (nd != 1) begin errors++; $display("FAIL drop_count: got %0d expected 1", nd); end
    checks++; if (td != DEB + 3) begin errors++; $display("FAIL drop_cycle: got %0d expected %0d", td, DEB + 3); end
    checks++; if (nv != 0) begin errors++; $display("FAIL drop_no_command: got %0d non-idle cycles expected 0", nv); end
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL drop_shadow: got %b expected 00", shadow_state); end
  endtask

  task automatic test_reset_mid_issue();
    int found;
    int nv;
    btn = 4'b0001;
    for (int i = 0; i < 12; i++) tick();
    btn = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (shadow_state !== 2'b01) begin errors++; $display("FAIL mid_setup_shadow: got %b expected 01", shadow_state); end
    btn   = 4'b1010;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (cmd_valid === 1'b1) found = 1;
    end
    checks++; if (found == 0 || command !== 3'b010) begin errors++; $display("FAIL mid_pause_issue: found %0d cmd %b expected 010", found, command); end
    reset = 1'b1;
    btn   = 4'h0;
    tick();
    checks++; if (command !== 3'b111 || cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_abort: got cmd %b valid %b expected 111 0", command, cmd_valid); end
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL mid_abort_shadow: got %b expected 00", shadow_state); end
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_valid === 1'b1 || dropped === 1'b1) nv++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL mid_prev_lost: got %0d events expected 0", nv); end
  endtask

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0) begin
        btn       = 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (command !== 3'(exp_cmd()) || cmd_valid !== (exp_cmd() != 7) ||
          dropped !== 1'(exp_drop()) || shadow_state !== 2'(shadow_m)) begin
        errors++;
        $display("FAIL random_cycle_%0d: got cmd %b valid %b drop %b shadow %b expected cmd %0d drop %0d shadow %0d",
                 i, command, cmd_valid, dropped, shadow_state, exp_cmd(), exp_drop(), shadow_m);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_play_latency();
    test_bounce();
    test_back_to_back();
    test_drop_in_load();
    test_reset_mid_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
